// File: rtl/idwt_pkg.sv
// Shared constants, element types and the pixel clamp for the 8x8 inverse Haar engine.
package idwt_pkg;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned N     = 8;
  localparam int unsigned ROW_W = N * PIX_W;
  localparam int unsigned V_W   = 10;
  localparam int unsigned H_W   = 11;

  typedef logic signed [V_W-1:0] v_elem_t;
  typedef v_elem_t v_row_t [N];

  // Saturate a horizontal-stage result into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [H_W-1:0] y);
    if (y[H_W-1])              return '0;
    else if (|y[H_W-2:PIX_W])  return '1;
    else                       return y[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/idwt_8x8_if.sv
// Row-word bus of the inverse DWT engine: eight coefficient rows in, eight pixel rows out.
interface idwt_8x8_if;
  import idwt_pkg::*;

  logic [ROW_W-1:0] inp1, inp2, inp3, inp4, inp5, inp6, inp7, inp8;
  logic [ROW_W-1:0] outp1, outp2, outp3, outp4, outp5, outp6, outp7, outp8;
  logic             idwt_valid;

  modport master (
    output inp1, inp2, inp3, inp4, inp5, inp6, inp7, inp8,
    input  outp1, outp2, outp3, outp4, outp5, outp6, outp7, outp8,
    input  idwt_valid
  );

  modport slave (
    input  inp1, inp2, inp3, inp4, inp5, inp6, inp7, inp8,
    output outp1, outp2, outp3, outp4, outp5, outp6, outp7, outp8,
    output idwt_valid
  );
endinterface

// File: rtl/idwt_haar1d.sv
// Combinational 8-point inverse Haar butterfly: out[2k] = a[k]+a[k+4], out[2k+1] = a[k]-a[k+4].
module idwt_haar1d #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  din  [idwt_pkg::N],
  output logic signed [OUT_W-1:0] dout [idwt_pkg::N]
);
  localparam int unsigned HALF = idwt_pkg::N / 2;

  always_comb begin
    for (int k = 0; k < HALF; k++) begin
      dout[2*k]   = OUT_W'(din[k]) + OUT_W'(din[k+HALF]);
      dout[2*k+1] = OUT_W'(din[k]) - OUT_W'(din[k+HALF]);
    end
  end
endmodule

// File: rtl/idwt_8x8.sv
// Streaming single-level 2D inverse Haar DWT: one 8x8 block per clock, three register stages.
module idwt_8x8
  import idwt_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  idwt_8x8_if.slave bus
);
  logic [ROW_W-1:0] in_q  [N];
  v_row_t           x_d   [N];
  v_row_t           x_q   [N];
  logic [ROW_W-1:0] out_d [N];
  logic [ROW_W-1:0] out_q [N];
  logic [2:0]       vld_sr;

  // Reg1: raw coefficient rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) in_q[r] <= '0;
    end else begin
      in_q[0] <= bus.inp1;
      in_q[1] <= bus.inp2;
      in_q[2] <= bus.inp3;
      in_q[3] <= bus.inp4;
      in_q[4] <= bus.inp5;
      in_q[5] <= bus.inp6;
      in_q[6] <= bus.inp7;
      in_q[7] <= bus.inp8;
    end
  end

  // Vertical pass per column; the LL quadrant is unsigned, every other band is two's complement.
  for (genvar c = 0; c < N; c++) begin : g_col
    logic signed [PIX_W:0] col [N];
    v_elem_t               vx  [N];
    for (genvar r = 0; r < N; r++) begin : g_el
      logic [PIX_W-1:0] e;
      assign e = in_q[r][ROW_W-1-PIX_W*c -: PIX_W];
      if (r < N/2 && c < N/2) begin : g_ll
        assign col[r] = {1'b0, e};
      end else begin : g_sgn
        assign col[r] = {e[PIX_W-1], e};
      end
      assign x_d[r][c] = vx[r];
    end
    idwt_haar1d #(.IN_W(PIX_W + 1), .OUT_W(V_W)) u_v (.din(col), .dout(vx));
  end

  // Reg2: vertical results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) x_q[r][c] <= '0;
    end else begin
      x_q <= x_d;
    end
  end

  // Horizontal pass per row, then clamp and pack back into a row word.
  for (genvar r = 0; r < N; r++) begin : g_row
    v_row_t                hx;
    logic signed [H_W-1:0] hy [N];
    logic [ROW_W-1:0]      pix;
    assign hx = x_q[r];
    idwt_haar1d #(.IN_W(V_W), .OUT_W(H_W)) u_h (.din(hx), .dout(hy));
    always_comb begin
      pix = '0;
      for (int c = 0; c < N; c++) pix[ROW_W-1-PIX_W*c -: PIX_W] = clamp_u8(hy[c]);
    end
    assign out_d[r] = pix;
  end

  // Reg3: output pixels plus the valid fill register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) out_q[r] <= '0;
      vld_sr <= '0;
    end else begin
      out_q  <= out_d;
      vld_sr <= {vld_sr[1:0], 1'b1};
    end
  end

  assign bus.outp1      = out_q[0];
  assign bus.outp2      = out_q[1];
  assign bus.outp3      = out_q[2];
  assign bus.outp4      = out_q[3];
  assign bus.outp5      = out_q[4];
  assign bus.outp6      = out_q[5];
  assign bus.outp7      = out_q[6];
  assign bus.outp8      = out_q[7];
  assign bus.idwt_valid = vld_sr[2];
endmodule

// File: tb/tb_idwt_8x8.sv
// Bench for idwt_8x8: directed vector table, reset/valid fill, long random stream, mid-stream reset.
module tb_idwt_8x8;
  import idwt_pkg::*;

  localparam int unsigned BLK_W = N * ROW_W;
  localparam int unsigned NSTREAM = 1024;

  typedef logic [N-1:0][ROW_W-1:0] blk_t;
  typedef struct {
    string name;
    blk_t  in_rows;
    blk_t  exp_rows;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  idwt_8x8_if bus ();
  idwt_8x8 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive(input blk_t b);
    bus.inp1 = b[0];
    bus.inp2 = b[1];
    bus.inp3 = b[2];
    bus.inp4 = b[3];
    bus.inp5 = b[4];
    bus.inp6 = b[5];
    bus.inp7 = b[6];
    bus.inp8 = b[7];
  endtask

  function automatic blk_t read_out();
    blk_t o;
    o[0] = bus.outp1;
    o[1] = bus.outp2;
    o[2] = bus.outp3;
    o[3] = bus.outp4;
    o[4] = bus.outp5;
    o[5] = bus.outp6;
    o[6] = bus.outp7;
    o[7] = bus.outp8;
    return o;
  endfunction

  task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic blk_t rand_blk();
    blk_t b;
    for (int r = 0; r < N; r++) b[r] = {$urandom(), $urandom()};
    return b;
  endfunction

  // Closed form per 2x2 output cell: LL +/- LH +/- HL +/- HH, then saturate.
  function automatic blk_t model(input blk_t b);
    int               cf [N][N];
    blk_t             o;
    logic [PIX_W-1:0] e;
    int               y, sa, sb;
    o = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        e = b[r][ROW_W-1-PIX_W*c -: PIX_W];
        if (r < 4 && c < 4) cf[r][c] = int'(e);
        else                cf[r][c] = int'($signed(e));
      end
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int a = 0; a < 2; a++)
          for (int bb = 0; bb < 2; bb++) begin
            sa = (a == 0) ? 1 : -1;
            sb = (bb == 0) ? 1 : -1;
            y = cf[i][j] + sa * cf[i+4][j] + sb * cf[i][j+4] + sa * sb * cf[i+4][j+4];
            if (y < 0) y = 0;
            else if (y > 255) y = 255;
            o[2*i+a][ROW_W-1-PIX_W*(2*j+bb) -: PIX_W] = 8'(y);
          end
    return o;
  endfunction

  initial begin
    vec_t vecs[$];
    vec_t v;
    blk_t hist[$];
    blk_t blk, blk0, got;

    rst = 1'b1;
    drive('0);

    v.name = "ll_dc";
    v.in_rows = '0;  v.in_rows[0] = 64'h6400_0000_0000_0000;
    v.exp_rows = '0; v.exp_rows[0] = 64'h6464_0000_0000_0000; v.exp_rows[1] = 64'h6464_0000_0000_0000;
    vecs.push_back(v);

    v.name = "ll_lh";
    v.in_rows = '0;  v.in_rows[0] = 64'h6400_0000_0000_0000; v.in_rows[4] = 64'h0A00_0000_0000_0000;
    v.exp_rows = '0; v.exp_rows[0] = 64'h6E6E_0000_0000_0000; v.exp_rows[1] = 64'h5A5A_0000_0000_0000;
    vecs.push_back(v);

    v.name = "clamp_hi";
    v.in_rows = '0;  v.in_rows[0] = 64'hFA00_0000_1400_0000; v.in_rows[4] = 64'h1400_0000_1400_0000;
    v.exp_rows = '0; v.exp_rows[0] = 64'hFFE6_0000_0000_0000; v.exp_rows[1] = 64'hE6E6_0000_0000_0000;
    vecs.push_back(v);

    v.name = "clamp_lo";
    v.in_rows = '0;  v.in_rows[4] = 64'h8000_0000_0000_0000;
    v.exp_rows = '0; v.exp_rows[1] = 64'h8080_0000_0000_0000;
    vecs.push_back(v);

    v.name = "hh_neg";
    v.in_rows = '0;  v.in_rows[0] = 64'h0A00_0000_0000_0000; v.in_rows[4] = 64'h0000_0000_FF00_0000;
    v.exp_rows = '0; v.exp_rows[0] = 64'h090B_0000_0000_0000; v.exp_rows[1] = 64'h0B09_0000_0000_0000;
    vecs.push_back(v);

    v.name = "ll_hl_mid";
    v.in_rows = '0;  v.in_rows[1] = 64'h0080_0000_0081_0000;
    v.exp_rows = '0; v.exp_rows[2] = 64'h0000_01FF_0000_0000; v.exp_rows[3] = 64'h0000_01FF_0000_0000;
    vecs.push_back(v);

    // Reset state and valid fill with an all-zero stream
    repeat (2) @(negedge clk);
    check("reset outp", read_out(), '0);
    check("reset valid", BLK_W'(bus.idwt_valid), '0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("fill valid edge%0d", k), BLK_W'(bus.idwt_valid), BLK_W'(k == 3));
    end
    check("zero block outp", read_out(), '0);

    // Directed table: hold each block until it has crossed all three stages
    foreach (vecs[n]) begin
      drive(vecs[n].in_rows);
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = read_out();
      for (int r = 0; r < N; r++)
        check($sformatf("%s row%0d", vecs[n].name, r), BLK_W'(got[r]), BLK_W'(vecs[n].exp_rows[r]));
    end

    // Back-to-back random blocks, each expected two edges after it is sampled
    for (int i = 0; i < NSTREAM + 3; i++) begin
      @(negedge clk);
      if (i >= 3) check($sformatf("stream blk%0d", i - 3), read_out(), model(hist[i-3]));
      if (i % 128 == 0) check($sformatf("stream valid c%0d", i), BLK_W'(bus.idwt_valid), BLK_W'(1));
      if (i < NSTREAM) begin
        blk = rand_blk();
        hist.push_back(blk);
        drive(blk);
      end
    end

    // Mid-stream reset clears outputs immediately, then the fill restarts
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset outp", read_out(), '0);
    check("mid reset valid", BLK_W'(bus.idwt_valid), '0);
    @(posedge clk);
    @(negedge clk);
    check("held reset outp", read_out(), '0);
    blk0 = rand_blk();
    drive(blk0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("refill valid edge%0d", k), BLK_W'(bus.idwt_valid), BLK_W'(k == 3));
      if (k < 3) begin
        check($sformatf("refill outp edge%0d", k), read_out(), '0);
        drive(rand_blk());
      end else begin
        check("refill first block", read_out(), model(blk0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
